fft_write_ram: RTL

FFT_WRITE_RAM -- requirements
Module: fft_write_ram

---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_bitrev.sv | 17 +
 rtl/fft_write_ram.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and defaults for the FFT input RAM writer
// Purpose: state encoding of the write FSM and default RAM geometry.
// Ports: none (package).
package fft_pkg;

  // Default RAM word width ({im,re}, each half DRAMWIDTH/2 bits) and address width.
  localparam int FFT_DRAMWIDTH = 32;
  localparam int FFT_ARAMWIDTH = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } fft_wr_state_t;

endpackage

// File: rtl/fft_bitrev.sv
// rtl/fft_bitrev.sv - combinational bit reversal of an address
// Purpose: maps a linear sample index to its bit-reversed RAM address.
// Ports:
//   din  - WIDTH-bit linear index
//   dout - WIDTH-bit bit-reversed index (dout[i] = din[WIDTH-1-i])
module fft_bitrev #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign dout[i] = din[WIDTH-1-i];
  end

endmodule

// File: rtl/fft_write_ram.sv
// rtl/fft_write_ram.sv - fills one FFT frame of complex samples into RAM
// Purpose: accepts N = 2^ARAMWIDTH samples after a start pulse, writes each
//   one to RAM a cycle after acceptance, then pulses frame_done for the reader.
// Build option: FFT_WRITE_BITREV_EN - write addresses are the bit-reversed
//   sample index instead of the linear index.
// Ports:
//   clk_in, rst_n_in       - clock, synchronous active-low reset
//   start_in               - arm a frame fill (IDLE only)
//   abort_in               - abandon the current frame
//   sample_valid, re_in, im_in, sample_ready - sample handshake
//   ram_addr, ram_wdata, write_en             - RAM write port ({im,re})
//   busy                   - not IDLE
//   frame_done             - one-cycle frame-complete pulse
module fft_write_ram
  import fft_pkg::*;
#(
  parameter int DRAMWIDTH = FFT_DRAMWIDTH,
  parameter int ARAMWIDTH = FFT_ARAMWIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   start_in,
  input  logic                   abort_in,
  input  logic                   sample_valid,
  input  logic [DRAMWIDTH/2-1:0] re_in,
  input  logic [DRAMWIDTH/2-1:0] im_in,
  output logic                   sample_ready,
  output logic [ARAMWIDTH-1:0]   ram_addr,
  output logic [DRAMWIDTH-1:0]   ram_wdata,
  output logic                   write_en,
  output logic                   busy,
  output logic                   frame_done
);

  localparam logic [ARAMWIDTH-1:0] CNT_LAST = '1;

  fft_wr_state_t        state;
  fft_wr_state_t        state_nxt;
  logic [ARAMWIDTH-1:0] cnt;
  logic [ARAMWIDTH-1:0] addr_map;
  logic                 accept;

  // Abort wins over a sample offered in the same cycle: it is neither written
  // nor counted. sample_ready is still high then because it depends on state only.
  assign accept = (state == ST_FILL) && sample_valid && !abort_in;

`ifdef FFT_WRITE_BITREV_EN
  fft_bitrev #(
    .WIDTH(ARAMWIDTH)
  ) u_bitrev (
    .din (cnt),
    .dout(addr_map)
  );
`else
  assign addr_map = cnt;
`endif

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_in) state_nxt = ST_FILL;
      ST_FILL: if (accept && (cnt == CNT_LAST)) state_nxt = ST_LAST;
      ST_LAST: state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort_in) state_nxt = ST_IDLE;
  end

  // State-decoded outputs
  always_comb begin
    sample_ready = 1'b0;
    busy         = 1'b1;
    frame_done   = 1'b0;
    case (state)
      ST_IDLE: busy         = 1'b0;
      ST_FILL: sample_ready = 1'b1;
      ST_DONE: frame_done   = 1'b1;
      default: ;
    endcase
  end

  // Sample counter; the increment after index N-1 wraps to 0 naturally.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (abort_in) begin
      cnt <= '0;
    end else if ((state == ST_IDLE) && start_in) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
    end
  end

  // One-cycle write pipeline. The final write lands in LAST, so frame_done
  // (DONE) can never overlap a write. A write registered before an abort
  // still goes out in the abort cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      write_en  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      write_en <= accept;
      if (accept) begin
        ram_addr  <= addr_map;
        ram_wdata <= {im_in, re_in};
      end
    end
  end

endmodule
